// File: rtl/avmm_memory_pkg.sv
// avmm_memory_pkg: shared request/response payloads for the avmm memory port.
//   avmm_req : 624 bits = read, write, address[45:0], writedata[511:0], timestamp[63:0]
//   avmm_rsp : 513 bits = readdatavalid, readdata[511:0]
package avmm_memory_pkg;

  localparam int unsigned AVMM_ADDR_W = 46;
  localparam int unsigned AVMM_DATA_W = 512;
  localparam int unsigned AVMM_TS_W   = 64;

  typedef struct packed {
    logic                   read;
    logic                   write;
    logic [AVMM_ADDR_W-1:0] address;
    logic [AVMM_DATA_W-1:0] writedata;
    logic [AVMM_TS_W-1:0]   timestamp;
  } avmm_req;

  typedef struct packed {
    logic                   readdatavalid;
    logic [AVMM_DATA_W-1:0] readdata;
  } avmm_rsp;

endpackage

// File: rtl/avmm_req_arbiter.sv
// avmm_req_arbiter: round-robin arbiter sharing one avmm memory port between
// NUM_REQ requesters, with an in-order tag FIFO that routes read data back.
//   clk, rst_n      : clock, asynchronous active-low reset
//   req_i           : per-requester request (valid = read | write)
//   req_ready_o     : one-hot grant, high only in the accept cycle
//   mem_req_o       : registered request toward memory, held under back-pressure
//   mem_ready_i     : memory accepts mem_req_o this cycle
//   mem_rsp_i       : in-order memory response
//   rsp_o           : registered, routed per-requester responses
//   outstanding_o   : reads accepted but not yet answered
//   protocol_err_o  : sticky error (read+write request, or response with no tag)
module avmm_req_arbiter
  import avmm_memory_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned MAX_OUTSTANDING = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  avmm_req [NUM_REQ-1:0]              req_i,
  output logic    [NUM_REQ-1:0]              req_ready_o,
  output avmm_req                            mem_req_o,
  input  logic                               mem_ready_i,
  input  avmm_rsp                            mem_rsp_i,
  output avmm_rsp [NUM_REQ-1:0]              rsp_o,
  output logic    [$clog2(MAX_OUTSTANDING):0] outstanding_o,
  output logic                               protocol_err_o
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CNT_W = PTR_W + 1;

  avmm_req                 mem_req_q, mem_req_d;
  avmm_rsp [NUM_REQ-1:0]   rsp_q, rsp_d;
  logic    [CNT_W-1:0]     cnt_q, cnt_d;
  logic    [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic    [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic    [ID_W-1:0]      tag_mem_q [MAX_OUTSTANDING];
  logic    [ID_W-1:0]      tag_mem_d [MAX_OUTSTANDING];
  logic    [ID_W-1:0]      rr_q, rr_d;
  logic                    err_q, err_d;

  logic                    slot_free;
  logic                    read_ok;
  logic    [NUM_REQ-1:0]   eligible;
  logic    [NUM_REQ-1:0]   gnt;
  logic                    gnt_any;
  logic    [ID_W-1:0]      gnt_id;
  int unsigned             scan_idx;
  logic                    push;
  logic                    pop;

  // Eligibility: slot free and valid; reads also need a free tag (no same-cycle pop credit)
  always_comb begin
    slot_free = !(mem_req_q.read | mem_req_q.write) | mem_ready_i;
    read_ok   = cnt_q < CNT_W'(MAX_OUTSTANDING);
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = rst_n & slot_free & (req_i[i].read | req_i[i].write)
                    & (!req_i[i].read | read_ok);
    end
  end

  // Round-robin scan starting at the pointer; first eligible index wins
  always_comb begin
    gnt      = '0;
    gnt_any  = 1'b0;
    gnt_id   = '0;
    scan_idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = (32'(rr_q) + 32'(k)) % NUM_REQ;
      if (!gnt_any && eligible[ID_W'(scan_idx)]) begin
        gnt_any = 1'b1;
        gnt_id  = ID_W'(scan_idx);
      end
    end
    if (gnt_any) begin
      gnt[gnt_id] = 1'b1;
    end
  end

  assign push = gnt_any & req_i[gnt_id].read;
  assign pop  = mem_rsp_i.readdatavalid & (cnt_q != '0);

  // Next-state: output slot, pointer, tag FIFO, response routing, error flag
  always_comb begin
    mem_req_d = mem_req_q;
    rsp_d     = '0;
    cnt_d     = cnt_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    tag_mem_d = tag_mem_q;
    rr_d      = rr_q;
    err_d     = err_q;

    if (slot_free) begin
      if (gnt_any) begin
        mem_req_d = req_i[gnt_id];
        // A read+write request is forwarded as a plain read
        if (req_i[gnt_id].read && req_i[gnt_id].write) begin
          mem_req_d.write = 1'b0;
          err_d           = 1'b1;
        end
        rr_d = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
      end else begin
        mem_req_d.read  = 1'b0;
        mem_req_d.write = 1'b0;
      end
    end

    if (push) begin
      tag_mem_d[wr_ptr_q] = gnt_id;
      wr_ptr_d            = wr_ptr_q + PTR_W'(1);
    end

    if (mem_rsp_i.readdatavalid) begin
      if (cnt_q != '0) begin
        rsp_d[tag_mem_q[rd_ptr_q]].readdatavalid = 1'b1;
        rsp_d[tag_mem_q[rd_ptr_q]].readdata      = mem_rsp_i.readdata;
        rd_ptr_d                                 = rd_ptr_q + PTR_W'(1);
      end else begin
        err_d = 1'b1;
      end
    end

    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req_q <= '0;
      rsp_q     <= '0;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rr_q      <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        tag_mem_q[i] <= '0;
      end
    end else begin
      mem_req_q <= mem_req_d;
      rsp_q     <= rsp_d;
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rr_q      <= rr_d;
      err_q     <= err_d;
      tag_mem_q <= tag_mem_d;
    end
  end

  assign req_ready_o    = gnt;
  assign mem_req_o      = mem_req_q;
  assign rsp_o          = rsp_q;
  assign outstanding_o  = cnt_q;
  assign protocol_err_o = err_q;

endmodule

// File: tb/tb_avmm_req_arbiter.sv
// Bench for avmm_req_arbiter: directed scenarios followed by randomized traffic,
// all checked against a queue-based reference model of the arbitration rules.
module tb_avmm_req_arbiter;
  import avmm_memory_pkg::*;

  localparam int NR   = 4;
  localparam int MAXO = 16;

  logic                 clk   = 1'b0;
  logic                 rst_n = 1'b1;
  avmm_req [NR-1:0]     req_i;
  logic    [NR-1:0]     req_ready_o;
  avmm_req              mem_req_o;
  logic                 mem_ready_i;
  avmm_rsp              mem_rsp_i;
  avmm_rsp [NR-1:0]     rsp_o;
  logic    [4:0]        outstanding_o;
  logic                 protocol_err_o;

  avmm_req_arbiter #(.NUM_REQ(NR), .MAX_OUTSTANDING(MAXO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_i          (req_i),
    .req_ready_o    (req_ready_o),
    .mem_req_o      (mem_req_o),
    .mem_ready_i    (mem_ready_i),
    .mem_rsp_i      (mem_rsp_i),
    .rsp_o          (rsp_o),
    .outstanding_o  (outstanding_o),
    .protocol_err_o (protocol_err_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  avmm_req          m_slot;
  int               m_tags[$];
  int               m_ptr;
  bit               m_err;
  avmm_rsp [NR-1:0] m_rsp;
  int               last_gnt;
  bit               mem_took_read;
  int               mem_inflight;

  task automatic chk(input string tag, input logic [623:0] obs, input logic [623:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic avmm_req mk(input bit rd, input bit wr, input logic [45:0] a);
    avmm_req r;
    r.read    = rd;
    r.write   = wr;
    r.address = a;
    for (int w = 0; w < 16; w++) r.writedata[w*32 +: 32] = $urandom;
    r.timestamp = {$urandom, $urandom};
    return r;
  endfunction

  function automatic avmm_rsp rnd_rsp();
    avmm_rsp r;
    r.readdatavalid = 1'b1;
    for (int w = 0; w < 16; w++) r.readdata[w*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    m_slot       = '0;
    m_tags.delete();
    m_ptr        = 0;
    m_err        = 1'b0;
    m_rsp        = '0;
    mem_inflight = 0;
  endtask

  task automatic check_outputs();
    chk("mem_req", 624'(mem_req_o), 624'(m_slot));
    chk("outstanding", 624'(outstanding_o), 624'(m_tags.size()));
    chk("protocol_err", 624'(protocol_err_o), 624'(m_err));
    for (int p = 0; p < NR; p++)
      chk($sformatf("rsp%0d", p), 624'(rsp_o[p]), 624'(m_rsp[p]));
  endtask

  // One clock cycle: predict grant from current inputs, advance model, check registered outputs
  task automatic step();
    int           g;
    bit           free;
    logic [623:0] e;
    #1;
    free = !(m_slot.read || m_slot.write) || mem_ready_i;
    g    = -1;
    for (int k = 0; k < NR; k++) begin
      int i;
      i = (m_ptr + k) % NR;
      if (g < 0 && free && (req_i[i].read || req_i[i].write) &&
          (!req_i[i].read || m_tags.size() < MAXO))
        g = i;
    end
    e = '0;
    if (g >= 0) e[g] = 1'b1;
    chk("req_ready", 624'(req_ready_o), e);
    mem_took_read = m_slot.read && mem_ready_i;
    last_gnt      = g;
    m_rsp         = '0;
    if (mem_rsp_i.readdatavalid) begin
      if (m_tags.size() > 0) begin
        int t;
        t        = m_tags.pop_front();
        m_rsp[t] = {1'b1, mem_rsp_i.readdata};
      end else begin
        m_err = 1'b1;
      end
    end
    if (free) begin
      if (g >= 0) begin
        m_slot = req_i[g];
        if (m_slot.read && m_slot.write) begin
          m_slot.write = 1'b0;
          m_err        = 1'b1;
        end
        if (m_slot.read) m_tags.push_back(g);
        m_ptr = (g + 1) % NR;
      end else begin
        m_slot.read  = 1'b0;
        m_slot.write = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    req_i       = '0;
    mem_ready_i = 1'b0;
    mem_rsp_i   = '0;
    model_reset();
    #2;
    check_outputs();
    chk("rst_ready", 624'(req_ready_o), '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    req_i       = '0;
    mem_ready_i = 1'b1;
    for (int n = 0; n < 40 && m_tags.size() > 0; n++) begin
      mem_rsp_i = rnd_rsp();
      step();
    end
    mem_rsp_i = '0;
    step();
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int      cnt[NR];
    int      ports[4];
    avmm_rsp d[4];
    #1;
    do_reset();

    // Single read on port 2, response five cycles later
    mem_ready_i = 1'b1;
    req_i[2]    = mk(1'b1, 1'b0, 46'h10);
    step();
    chk("s1_read", 624'(mem_req_o.read), 624'(1));
    chk("s1_addr", 624'(mem_req_o.address), 624'(46'h10));
    req_i[2] = '0;
    repeat (4) step();
    mem_rsp_i = {1'b1, 512'hA5};
    step();
    chk("s1_rsp2", 624'(rsp_o[2]), 624'({1'b1, 512'hA5}));
    chk("s1_out", 624'(outstanding_o), 624'(0));
    mem_rsp_i = '0;
    step();

    // Round-robin fairness with continuous writes
    for (int p = 0; p < NR; p++) begin
      cnt[p]   = 0;
      req_i[p] = mk(1'b0, 1'b1, 46'($urandom));
    end
    repeat (40) begin
      step();
      if (last_gnt >= 0) begin
        cnt[last_gnt]++;
        req_i[last_gnt] = mk(1'b0, 1'b1, 46'($urandom));
      end
    end
    for (int p = 0; p < NR; p++) chk($sformatf("fair%0d", p), 624'(cnt[p]), 624'(10));

    // Back-pressure with a loaded slot
    mem_ready_i = 1'b0;
    repeat (5) begin
      step();
      chk("bp_ready", 624'(req_ready_o), '0);
    end
    mem_ready_i = 1'b1;
    step();
    chk("bp_gnt", 624'(last_gnt >= 0), 624'(1));
    req_i = '0;
    step();
    step();

    // Outstanding limit
    for (int n = 0; n < MAXO; n++) begin
      req_i[0] = mk(1'b1, 1'b0, 46'(n));
      step();
      req_i[0] = '0;
    end
    chk("lim_full", 624'(outstanding_o), 624'(16));
    req_i[0] = mk(1'b1, 1'b0, 46'h77);
    req_i[1] = mk(1'b0, 1'b1, 46'h88);
    step();
    chk("lim_wr_gnt", 624'(last_gnt), 624'(1));
    req_i[1]  = '0;
    mem_rsp_i = rnd_rsp();
    step();
    chk("lim_pop", 624'(outstanding_o), 624'(15));
    mem_rsp_i = '0;
    step();
    chk("lim_rd_gnt", 624'(last_gnt), 624'(0));
    drain();

    // Interleaved routing
    ports = '{3, 0, 3, 1};
    for (int n = 0; n < 4; n++) begin
      req_i[ports[n]] = mk(1'b1, 1'b0, 46'(n));
      step();
      req_i[ports[n]] = '0;
    end
    for (int n = 0; n < 4; n++) begin
      d[n]      = rnd_rsp();
      mem_rsp_i = d[n];
      step();
      chk($sformatf("route%0d", n), 624'(rsp_o[ports[n]]), 624'(d[n]));
    end
    mem_rsp_i = '0;
    step();

    // Read and write both set
    req_i[1] = mk(1'b1, 1'b1, 46'h5);
    step();
    req_i[1] = '0;
    chk("rw_write", 624'(mem_req_o.write), 624'(0));
    chk("rw_read", 624'(mem_req_o.read), 624'(1));
    chk("rw_err", 624'(protocol_err_o), 624'(1));
    drain();

    // Reset mid-operation, then a stray response
    do_reset();
    mem_ready_i = 1'b1;
    req_i[2]    = mk(1'b1, 1'b0, 46'h9);
    step();
    req_i[2] = '0;
    step();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    rst_n       = 1'b1;
    mem_ready_i = 1'b1;
    mem_rsp_i   = rnd_rsp();
    step();
    chk("stray_err", 624'(protocol_err_o), 624'(1));
    chk("stray_rsp2", 624'(rsp_o[2].readdatavalid), 624'(0));
    mem_rsp_i = '0;
    step();

    // Randomized traffic
    do_reset();
    repeat (1500) begin
      for (int p = 0; p < NR; p++) begin
        if (!(req_i[p].read || req_i[p].write) && ($urandom % 2 == 0)) begin
          int kind;
          kind = $urandom % 50;
          req_i[p] = mk(kind < 24 || kind == 49, kind >= 24, 46'($urandom));
        end
      end
      mem_ready_i = ($urandom % 4) != 0;
      if (mem_inflight > 0 && ($urandom % 3 == 0)) mem_rsp_i = rnd_rsp();
      else                                         mem_rsp_i = '0;
      step();
      if (mem_rsp_i.readdatavalid) mem_inflight--;
      if (mem_took_read)           mem_inflight++;
      if (last_gnt >= 0)           req_i[last_gnt] = '0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
